mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Issue/retire controller for the two-stage Booth/Wallace multiplier in the EX→MEM path. It accepts multiply ops from EX over a valid/ready handshake and drives the datapath operands and signedness. It tracks the op in flight through the datapath's internal register, selects the low or high 32-bit word of the 64-bit product, and buffers results in a 2-entry output queue so that MEM back-pressure never loses a product.

## Interface
- TAG_W, default 5: width of the destination-register tag carried alongside each op.
- mul_clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  EX presents an op this cycle.
- in_ready  output  1  controller accepts the op this cycle.
- in_op  input  2  op code (encodings listed under Operation).
- in_x  input  32  multiplicand.
- in_y  input  32  multiplier.
- in_tag  input  TAG_W  destination tag; returned unchanged.
- flush  input  1  pipeline flush; cancels every op held in the block.
- out_valid  output  1  result available.
- out_ready  input  1  MEM consumes the result.
- out_data  output  32  selected result word.
- out_tag  output  TAG_W  tag of out_data.
- busy  output  1  any op is in flight or queued.

## Operation
- Op encodings:
  - OP_MUL = 00: low word, signed datapath.
  - OP_MULH = 01: high word, signed.
  - OP_MULHU = 10: high word, unsigned.
  - 11: decodes as OP_MUL.
- Issue:
  - Fires when in_valid && in_ready.
  - in_x, in_y and the signedness bit (1 for 00/01/11, 0 for 10) drive the datapath combinationally in the issue cycle. The datapath captures its partial products at that edge.
  - At the same edge the controller sets s1_valid and stores s1_hi (high/low select) and s1_tag.
- Stage 1:
  - s1 always leaves at the next edge. The datapath register has no hold, so the slot cannot stall.
  - The selected word (result[63:32] if s1_hi, else result[31:0]) and s1_tag are pushed into the output queue.
  - s1_valid clears unless a new issue occurs at that edge.
- Output queue:
  - 2-entry FIFO of {data, tag}.
  - Head drives out_data and out_tag. out_valid = (count != 0).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Ready rule: in_ready = resetn && !flush && (s1_valid + count - pop) < 2.
  - This guarantees the queue never overflows, because s1 + count ≤ 2 is invariant.
  - in_ready depends combinationally on out_ready.
- busy = s1_valid || count != 0.
- Flush:
  - At the edge, clears s1_valid, count, and the head/tail pointers.
  - A pop in the flush cycle still completes for MEM, but its entry is discarded with the rest.
  - No issue occurs in the flush cycle.
- Reset:
  - Asynchronous reset clears s1_valid, the queue, and the registered data/tag.
  - Reset values: out_valid 0, out_data 0, out_tag 0, busy 0, in_ready 0.
  - Reset asserted mid-operation drops all in-flight ops. No result appears after release.

## Timing
- Latency: issue at edge T; the result is pushed at edge T+1; out_valid is high during cycle T+1→T+2 (first visible after edge T+1).
- Equivalently, the result is visible 2 cycles after the in_valid cycle begins.
- Throughput: 1 op/cycle while out_ready stays high.
- With out_ready low, at most 2 results are held. in_ready drops once s1 plus the queue total 2.
- Drain order is strictly FIFO.
- Simultaneous cases:
  - flush beats issue.
  - Push and pop together are legal at count = 2 only if a pop happens; the ready rule guarantees this.

## Structure
- Shared package mul_pkg holds:
  - OP_MUL / OP_MULH / OP_MULHU localparams.
  - The op-to-signedness and op-to-hi-select decode function.
- Datapath sub-module: the existing mul, instantiated once.
  - mul_clk is shared with it.
  - Its resetn is tied to the controller's resetn.
- The output queue is inline (two entries, 1-bit pointers). It does not get its own module.

## Test plan
- OP_MUL, x=7, y=6, tag=3 → out_valid rises 2 cycles after issue, out_data=0x0000002A, out_tag=3.
- OP_MULH, x=0x80000000, y=0x80000000 → out_data=0x40000000. OP_MUL with x=y=0xFFFFFFFF → out_data=0x00000001.
- OP_MULHU, x=y=0xFFFFFFFF → out_data=0xFFFFFFFE. Same operands with OP_MULH → 0x00000000.
- Back-to-back burst of 8 ops with out_ready=1 → in_ready stays 1 and 8 results arrive on consecutive cycles in order, tags intact.
- Back-pressure: out_ready=0, issue ops A, B, C:
  - A and B are accepted and C stalls.
  - Then out_ready=1 → A, B, C are returned in order with none lost.
- Flush with s1 and the queue occupied → next cycle out_valid=0 and busy=0, and no flushed result ever appears. resetn pulsed mid-burst behaves the same, and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue/retire controller:
// op encodings and the op-to-datapath-control decode.
package mul_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b10;

  typedef struct packed {
    logic isSigned;
    logic hiSel;
  } opDecode_t;

  // Encoding 11 is reserved and folds onto OP_MUL.
  function automatic opDecode_t decodeOp(input logic [1:0] op);
    opDecode_t d;
    case (op)
      OP_MUL:   begin d.isSigned = 1'b1; d.hiSel = 1'b0; end
      OP_MULH:  begin d.isSigned = 1'b1; d.hiSel = 1'b1; end
      OP_MULHU: begin d.isSigned = 1'b0; d.hiSel = 1'b1; end
      default:  begin d.isSigned = 1'b1; d.hiSel = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul.sv
// Two-stage 32x32 multiplier datapath: partial products are captured on every
// edge (no hold), and the 64-bit product is summed from them in the next cycle.
module mul (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        isSigned,
  output logic [63:0] result
);

  logic [32:0]        xExt, yExt;
  logic [15:0]        xLo, yLo;
  logic signed [16:0] xHi, yHi;
  logic signed [33:0] xLoW, yLoW, xHiW, yHiW;
  logic [31:0]        pLLNext, pLL;
  logic signed [33:0] pLHNext, pHLNext, pHHNext;
  logic signed [33:0] pLH, pHL, pHH;
  logic [63:0]        eLH, eHL, eHH;

  // Operands are widened to 33 bits so signed and unsigned share one array;
  // each splits into an unsigned low half and a signed high half.
  always_comb begin
    xExt    = {isSigned & x[31], x};
    yExt    = {isSigned & y[31], y};
    xLo     = xExt[15:0];
    yLo     = yExt[15:0];
    xHi     = xExt[32:16];
    yHi     = yExt[32:16];
    xLoW    = {18'd0, xLo};
    yLoW    = {18'd0, yLo};
    xHiW    = {{17{xHi[16]}}, xHi};
    yHiW    = {{17{yHi[16]}}, yHi};
    pLLNext = {16'd0, xLo} * {16'd0, yLo};
    pLHNext = xLoW * yHiW;
    pHLNext = xHiW * yLoW;
    pHHNext = xHiW * yHiW;
  end

  // Partial-product register; recaptured unconditionally every cycle.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      pLL <= 32'd0;
      pLH <= 34'sd0;
      pHL <= 34'sd0;
      pHH <= 34'sd0;
    end else begin
      pLL <= pLLNext;
      pLH <= pLHNext;
      pHL <= pHLNext;
      pHH <= pHHNext;
    end
  end

  // Second stage: weighted sum of the partial products, modulo 2^64.
  always_comb begin
    eLH    = {{30{pLH[33]}}, pLH};
    eHL    = {{30{pHL[33]}}, pHL};
    eHH    = {{30{pHH[33]}}, pHH};
    result = (eHH << 32) + ((eLH + eHL) << 16) + {32'd0, pLL};
  end

endmodule

// File: rtl/mul_ctrl.sv
// Issue/retire controller for the two-stage multiplier: tracks the op inside the
// datapath register and buffers results in a 2-entry queue against MEM stalls.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  opDecode_t        dec;
  logic [63:0]      product;
  logic             issue, push, pop;
  logic [2:0]       heldAfterPop;
  logic [31:0]      pushData;

  logic             s1Valid;
  logic             s1Hi;
  logic [TAG_W-1:0] s1Tag;

  logic [31:0]      qData [2];
  logic [TAG_W-1:0] qTag  [2];
  logic             headPtr, tailPtr;
  logic [1:0]       count, countNext;

  assign dec = decodeOp(in_op);

  mul uMul (
    .mul_clk  (mul_clk),
    .resetn   (resetn),
    .x        (in_x),
    .y        (in_y),
    .isSigned (dec.isSigned),
    .result   (product)
  );

  // Handshake and occupancy: s1 plus the queue may never exceed two entries.
  always_comb begin
    out_valid    = (count != 2'd0);
    pop          = out_valid & out_ready;
    push         = s1Valid;
    heldAfterPop = {2'd0, s1Valid} + {1'b0, count} - {2'd0, pop};
    in_ready     = resetn & ~flush & (heldAfterPop < 3'd2);
    issue        = in_valid & in_ready;
    busy         = s1Valid | out_valid;
    pushData     = s1Hi ? product[63:32] : product[31:0];
    out_data     = qData[headPtr];
    out_tag      = qTag[headPtr];
  end

  // Queue count update for each push/pop combination.
  always_comb begin
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + 2'd1;
      2'b01:   countNext = count - 2'd1;
      default: countNext = count;
    endcase
  end

  // Stage-1 tracker mirrors the op held in the datapath register.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1Valid <= 1'b0;
      s1Hi    <= 1'b0;
      s1Tag   <= {TAG_W{1'b0}};
    end else if (flush) begin
      s1Valid <= 1'b0;
    end else begin
      s1Valid <= issue;
      if (issue) begin
        s1Hi  <= dec.hiSel;
        s1Tag <= in_tag;
      end
    end
  end

  // Queue pointers and count; a flush discards everything including a same-cycle push.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        tailPtr <= ~tailPtr;
      end
      if (pop) begin
        headPtr <= ~headPtr;
      end
      count <= countNext;
    end
  end

  // Queue storage; the ready rule guarantees the tail slot is free on a push.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        qData[i] <= 32'd0;
        qTag[i]  <= {TAG_W{1'b0}};
      end
    end else if (push && !flush) begin
      qData[tailPtr] <= pushData;
      qTag[tailPtr]  <= s1Tag;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed test-plan steps followed by random
// traffic, checked against a queue-based behavioural model of held results.
module tb_mul_ctrl;

  localparam int TAG_W = 5;

  logic             mul_clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_x, in_y;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               issuedAt;
  } held_t;

  held_t mq[$];

  mul_ctrl #(.TAG_W(TAG_W)) dut (
    .mul_clk   (mul_clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 mul_clk = ~mul_clk;

  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    if (op == 2'b10) p = {32'd0, x} * {32'd0, y};
    else             p = sx * sy;
    return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] tag, input logic fl, input logic ordy);
    logic expValid, expPop, expReady;
    held_t h;
    @(negedge mul_clk);
    in_valid = v; in_op = op; in_x = x; in_y = y; in_tag = tag; flush = fl; out_ready = ordy;
    #1;
    expValid = (mq.size() > 0) && (mq[0].issuedAt <= edgeCnt - 1);
    check("out_valid", {31'd0, out_valid}, {31'd0, expValid});
    if (expValid) begin
      check("out_data", out_data, mq[0].data);
      check("out_tag", {27'd0, out_tag}, {27'd0, mq[0].tag});
    end
    expPop   = expValid && ordy;
    expReady = !fl && ((mq.size() - (expPop ? 1 : 0)) < 2);
    check("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    check("busy", {31'd0, busy}, {31'd0, (mq.size() != 0)});
    @(posedge mul_clk);
    edgeCnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (expPop) void'(mq.pop_front());
      if (v && expReady) begin
        h.data = refMul(op, x, y);
        h.tag = tag;
        h.issuedAt = edgeCnt;
        mq.push_back(h);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, '0, 1'b0, ordy);
  endtask

  // Check a literal head value without popping it.
  task automatic expectHead(input string name, input logic [31:0] lit, input logic [TAG_W-1:0] tag);
    @(negedge mul_clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(name, out_data, lit);
    check({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_out_data"}, out_data, 32'd0);
    check({name, "_out_tag"}, {27'd0, out_tag}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Directed one-op test: issue, wait for visibility, compare literal, drain.
  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] tag, input logic [31:0] lit);
    cycle(1'b1, op, x, y, tag, 1'b0, 1'b0);
    idle(1'b0);
    expectHead(name, lit, tag);
    idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_x = 32'd0; in_y = 32'd0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge mul_clk);
    resetn = 1'b1;

    directed("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'h0000002A);
    directed("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000);
    directed("mul_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001);
    directed("mulhu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE);
    directed("mulh_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000);
    directed("op11_as_mul", 2'b11, 32'hFFFFFFFD, 32'd5, 5'd8, 32'hFFFFFFF1);

    // Back-to-back burst with MEM always ready.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i + 10), 1'b0, 1'b1);
    end
    repeat (3) idle(1'b1);

    // Back-pressure: A, B accepted, C stalls until MEM drains.
    cycle(1'b1, 2'b00, 32'd11, 32'd3, 5'd21, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'd12, 32'd3, 5'd22, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 2'b00, 32'd13, 32'd3, 5'd23, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'd13, 32'd3, 5'd23, 1'b0, 1'b1);
    repeat (4) idle(1'b1);

    // Flush with s1 and the queue occupied.
    cycle(1'b1, 2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd24, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd25, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'd1, 32'd1, 5'd26, 1'b1, 1'b1);
    repeat (4) idle(1'b1);

    // Asynchronous reset mid-burst.
    cycle(1'b1, 2'b00, 32'd9, 32'd9, 5'd27, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'd8, 32'd8, 5'd28, 1'b0, 1'b0);
    @(negedge mul_clk);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1 checkResetOutputs("async_reset");
    mq.delete();
    @(posedge mul_clk);
    @(negedge mul_clk);
    resetn = 1'b1;
    repeat (4) idle(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
            5'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end
    repeat (4) idle(1'b1);
    check("drained", 32'(mq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
